// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: two-phase write/read-back self test for a single-port RAM.
// Owns the RAM address, write data and write enable; reports pass/fail stats.
module ram_bist_ctrl #(
    parameter int DATA_W = 8,
    parameter int SIZE   = 8,
    parameter int ADDR_W = 3,
    parameter int ERR_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_pattern,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_wr_en,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [ERR_W-1:0]  o_err_count,
    output logic [ADDR_W-1:0] o_first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(SIZE - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX = '1;

    state_t              state, state_n;
    logic                phase, phase_n;
    logic [DATA_W-1:0]   pat, pat_n;
    logic                cmp_valid, cmp_valid_n;
    logic [ADDR_W-1:0]   cmp_addr, cmp_addr_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [DATA_W-1:0]   wr_data_n;
    logic                wr_en_n;
    logic                busy_n;
    logic                done_n;
    logic                pass_n;
    logic [ERR_W-1:0]    err_n;
    logic [ADDR_W-1:0]   first_n;
    logic                mismatch;

    // Expected word: pattern xor address, inverted in phase 1.
    function automatic logic [DATA_W-1:0] exp_word(
        input logic [DATA_W-1:0] p,
        input logic [ADDR_W-1:0] a,
        input logic              ph
    );
        return (p ^ DATA_W'(a)) ^ {DATA_W{ph}};
    endfunction

    // Next-state and next-output logic; compare runs one cycle behind reads.
    always_comb begin
        state_n     = state;
        phase_n     = phase;
        pat_n       = pat;
        cmp_valid_n = (state == S_RD);
        cmp_addr_n  = o_addr;
        addr_n      = o_addr;
        wr_data_n   = o_wr_data;
        wr_en_n     = o_wr_en;
        busy_n      = o_busy;
        done_n      = 1'b0;
        pass_n      = o_pass;
        err_n       = o_err_count;
        first_n     = o_first_err_addr;

        mismatch = cmp_valid &&
                   (i_rd_data != exp_word(pat, cmp_addr, phase));
        if (mismatch) begin
            if (o_err_count != ERR_MAX) begin
                err_n = o_err_count + ERR_W'(1);
            end
            if (o_err_count == '0) begin
                first_n = cmp_addr;
            end
        end

        unique case (state)
            S_IDLE: begin
                wr_en_n = 1'b0;
                busy_n  = 1'b0;
                if (i_start) begin
                    pat_n     = i_pattern;
                    err_n     = '0;
                    first_n   = '0;
                    pass_n    = 1'b0;
                    phase_n   = 1'b0;
                    state_n   = S_WR;
                    addr_n    = '0;
                    wr_en_n   = 1'b1;
                    wr_data_n = exp_word(i_pattern, '0, 1'b0);
                    busy_n    = 1'b1;
                end
            end
            S_WR: begin
                if (o_addr == LAST) begin
                    state_n = S_RD;
                    addr_n  = '0;
                    wr_en_n = 1'b0;
                end else begin
                    addr_n    = o_addr + ADDR_W'(1);
                    wr_data_n = exp_word(pat, addr_n, phase);
                end
            end
            S_RD: begin
                if (o_addr == LAST) begin
                    state_n = S_FLUSH;
                    addr_n  = '0;
                end else begin
                    addr_n = o_addr + ADDR_W'(1);
                end
            end
            S_FLUSH: begin
                if (!phase) begin
                    phase_n   = 1'b1;
                    state_n   = S_WR;
                    addr_n    = '0;
                    wr_en_n   = 1'b1;
                    wr_data_n = exp_word(pat, '0, 1'b1);
                end else begin
                    state_n = S_DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (err_n == '0);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                wr_en_n = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any test in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= S_IDLE;
            phase            <= 1'b0;
            pat              <= '0;
            cmp_valid        <= 1'b0;
            cmp_addr         <= '0;
            o_addr           <= '0;
            o_wr_data        <= '0;
            o_wr_en          <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_pass           <= 1'b0;
            o_err_count      <= '0;
            o_first_err_addr <= '0;
        end else begin
            state            <= state_n;
            phase            <= phase_n;
            pat              <= pat_n;
            cmp_valid        <= cmp_valid_n;
            cmp_addr         <= cmp_addr_n;
            o_addr           <= addr_n;
            o_wr_data        <= wr_data_n;
            o_wr_en          <= wr_en_n;
            o_busy           <= busy_n;
            o_done           <= done_n;
            o_pass           <= pass_n;
            o_err_count      <= err_n;
            o_first_err_addr <= first_n;
        end
    end

endmodule
